// File: rtl/pkt_bus_arbiter.sv
// pkt_bus_arbiter: round-robin, packet-granular arbiter sharing one sink among NREQ DMA requesters
module pkt_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 32,
    parameter int MAXBEATS = 16
) (
    input  logic                    p_clk,
    input  logic                    n_rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         grant,
    output logic                    ready,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_pend,
    output logic [DSIZE-1:0]        m_data,
    output logic                    m_valid,
    output logic                    m_pkt_end,
    input  logic                    sink_ready,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    err
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(MAXBEATS);

    typedef enum logic [1:0] {IDLE, SETTLE, XFER} state_t;

    state_t            state, state_nxt;
    logic [NREQ-1:0]   grant_nxt, rot;
    logic [2*NREQ-1:0] dbl;
    logic [OW-1:0]     owner_nxt, rr_last, rr_last_nxt, pick;
    logic [CW-1:0]     beat_cnt, beat_cnt_nxt;
    logic              err_nxt, abort, own_req, own_pend, beat;
    logic [DSIZE-1:0]  own_data;
    int                off;

    assign m_valid   = state == XFER;
    assign ready     = m_valid && sink_ready;
    assign beat      = ready;
    assign m_data    = m_valid ? own_data : '0;
    assign m_pkt_end = m_valid && own_pend;
    assign busy      = state != IDLE;

    // route the current owner's request, data and pkt_end lanes
    always_comb begin
        own_req  = 1'b0;
        own_pend = 1'b0;
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == OW'(i)) begin
                own_req  = req[i];
                own_pend = req_pend[i];
                own_data = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    // rotate requests so the one just after rr_last sits at bit 0, then take the lowest set bit
    always_comb begin
        dbl = {req, req} >> (rr_last + 1'b1);
        rot = dbl[NREQ-1:0];
        off = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) off = j;
        end
        pick = OW'((int'(rr_last) + 1 + off) % NREQ);
    end

    // packet FSM: grant on request, one settle cycle, transfer until pkt_end or abort
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        owner_nxt    = owner;
        rr_last_nxt  = rr_last;
        beat_cnt_nxt = beat_cnt;
        err_nxt      = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt    = SETTLE;
                    grant_nxt    = NREQ'(1) << pick;
                    owner_nxt    = pick;
                    rr_last_nxt  = pick;
                    beat_cnt_nxt = '0;
                end
            end
            SETTLE: begin
                if (own_req) state_nxt = XFER;
                else abort = 1'b1;
            end
            XFER: begin
                if (beat && own_pend) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (beat) begin
                    if (beat_cnt == CW'(MAXBEATS - 1)) abort = 1'b1;
                    else beat_cnt_nxt = beat_cnt + 1'b1;
                end else if (!own_req) begin
                    abort = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            err_nxt   = 1'b1;
        end
    end

    // state and bookkeeping registers; async reset makes requester 0 first in rotation
    always_ff @(posedge p_clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_last  <= OW'(NREQ - 1);
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            owner    <= owner_nxt;
            rr_last  <= rr_last_nxt;
            beat_cnt <= beat_cnt_nxt;
            err      <= err_nxt;
        end
    end
endmodule

// File: tb/tb_pkt_bus_arbiter.sv
// tb_pkt_bus_arbiter: directed and randomized checks of packet arbitration against a transaction-level model
module tb_pkt_bus_arbiter;
    localparam int NREQ = 4, DSIZE = 32, MAXBEATS = 16;

    logic p_clk = 1'b0, n_rst = 1'b0;
    logic [NREQ-1:0] req = '0, req_pend, grant;
    logic ready, m_valid, m_pkt_end, sink_ready = 1'b0, busy, err;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [DSIZE-1:0] m_data;
    logic [1:0] owner;

    int checks = 0, errors = 0;
    int bidx [NREQ];
    int len [NREQ];
    logic [NREQ-1:0] pend_en = '1;
    int m_last = NREQ - 1;
    logic [15:0] salt = 16'h5a3c;
    int order[$];
    logic [NREQ-1:0] mask;
    int idx;

    always #5 p_clk = ~p_clk;

    pkt_bus_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBEATS(MAXBEATS)) dut (
        .p_clk(p_clk), .n_rst(n_rst), .req(req), .grant(grant), .ready(ready),
        .req_data(req_data), .req_pend(req_pend), .m_data(m_data), .m_valid(m_valid),
        .m_pkt_end(m_pkt_end), .sink_ready(sink_ready), .owner(owner), .busy(busy), .err(err)
    );

    function automatic logic [DSIZE-1:0] dat(input int i, input int b);
        return {4'hd, 4'(i), 8'(b), salt};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DSIZE +: DSIZE] = dat(i, bidx[i]);
            req_pend[i] = pend_en[i] && (bidx[i] == len[i] - 1);
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0] a;
        a = grant & {NREQ{ready}};
        @(posedge p_clk);
        for (int i = 0; i < NREQ; i++) if (a[i]) bidx[i]++;
        @(negedge p_clk);
        drive_data();
    endtask

    task automatic wait_grant(input int exp_n);
        int n;
        n = 0;
        while (grant == '0 && n < 50) begin
            tick();
            n++;
        end
        chk("grant_latency", 64'(n), 64'(exp_n));
    endtask

    task automatic serve(input int w, input int mode);
        int beats, cyc;
        logic acc;
        logic [NREQ-1:0] g;
        beats = 0;
        cyc = 0;
        g = NREQ'(1) << w;
        sink_ready = 1'b1;
        drive_data();
        #1;
        chk("settle_grant", grant, g);
        chk("settle_owner", owner, 64'(w));
        chk("settle_valid", m_valid, 0);
        chk("settle_ready", ready, 0);
        chk("settle_busy", busy, 1);
        tick();
        while (beats < len[w] && cyc < 400) begin
            sink_ready = (mode == 0) ? 1'b1 : (mode == 2) ? (cyc % 3 == 0) : ($urandom_range(0, 3) != 0);
            drive_data();
            #1;
            chk("xfer_valid", m_valid, 1);
            chk("xfer_grant", grant, g);
            chk("xfer_ready", ready, sink_ready);
            chk("xfer_data", m_data, dat(w, beats));
            chk("xfer_end", m_pkt_end, 64'(pend_en[w] && beats == len[w] - 1));
            chk("xfer_err", err, 0);
            acc = sink_ready;
            tick();
            if (acc) beats++;
            cyc++;
        end
        chk("pkt_beats", 64'(beats), 64'(len[w]));
        chk("release_grant", grant, 0);
        chk("release_busy", busy, 0);
        chk("release_valid", m_valid, 0);
        chk("release_err", err, 0);
        bidx[w] = 0;
        m_last = w;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(negedge p_clk);
        n_rst = 1'b1;
        m_last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) bidx[i] = 0;
        drive_data();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            bidx[i] = 0;
            len[i] = 4;
        end
        drive_data();
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ready", ready, 0);
        @(negedge p_clk);
        n_rst = 1'b1;

        // T1: lone requester 0, four-beat packet
        req = 4'b0001;
        drive_data();
        wait_grant(1);
        serve(0, 0);
        req = '0;
        tick();
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_err", err, 0);

        // T2: all request, rotation 0,1,2,3,0 with one idle cycle between packets
        do_reset();
        req = '1;
        drive_data();
        for (int j = 0; j < 5; j++) begin
            wait_grant(1);
            serve(j % NREQ, 0);
        end
        req = '0;

        // T3: sink stalls 1,0,0,1,... ; data held, exactly four beats
        req = 4'b0001;
        drive_data();
        wait_grant(1);
        serve(0, 2);
        req = '0;

        // T4: requester 0 never ends its packet; watchdog aborts on the 16th beat
        do_reset();
        pend_en = 4'b1110;
        req = 4'b0011;
        drive_data();
        wait_grant(1);
        chk("t4_grant", grant, 4'b0001);
        sink_ready = 1'b1;
        tick();
        for (int b = 0; b < MAXBEATS; b++) begin
            drive_data();
            #1;
            chk("t4_data", m_data, dat(0, b));
            chk("t4_grant_hold", grant, 4'b0001);
            chk("t4_no_err", err, 0);
            tick();
        end
        chk("t4_abort_err", err, 1);
        chk("t4_abort_grant", grant, 0);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_owner", owner, 0);
        bidx[0] = 0;
        pend_en = '1;
        drive_data();
        wait_grant(1);
        chk("t4_err_clear", err, 0);
        serve(1, 0);
        req = '0;

        // T5: owner withdraws during a stall; abort keeps rr_last at the aborted owner
        req = 4'b0100;
        drive_data();
        wait_grant(1);
        chk("t5_grant", grant, 4'b0100);
        sink_ready = 1'b1;
        tick();
        for (int b = 0; b < 2; b++) begin
            drive_data();
            #1;
            chk("t5_data", m_data, dat(2, b));
            tick();
        end
        sink_ready = 1'b0;
        req = '0;
        drive_data();
        #1;
        chk("t5_stall_ready", ready, 0);
        chk("t5_stall_valid", m_valid, 1);
        tick();
        chk("t5_err", err, 1);
        chk("t5_grant", grant, 0);
        chk("t5_busy", busy, 0);
        chk("t5_owner", owner, 2);
        bidx[2] = 0;
        req = '1;
        drive_data();
        wait_grant(1);
        chk("t5_err_clear", err, 0);
        serve(3, 0);
        req = '0;

        // T6: async reset during the second beat
        req = 4'b0001;
        drive_data();
        wait_grant(1);
        sink_ready = 1'b1;
        tick();
        drive_data();
        #1;
        tick();
        drive_data();
        #1;
        chk("t6_beat2_data", m_data, dat(0, 1));
        n_rst = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_data", m_data, 0);
        chk("t6_rst_owner", owner, 0);
        @(negedge p_clk);
        chk("t6_rst_err_hold", err, 0);
        n_rst = 1'b1;
        m_last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) bidx[i] = 0;
        req = 4'b0011;
        drive_data();
        wait_grant(1);
        serve(0, 0);
        req[0] = 1'b0;
        drive_data();
        wait_grant(1);
        serve(1, 0);
        req = '0;

        // random rounds: rotation order from a shrinking request set, random lengths and stalls
        for (int r = 0; r < 8; r++) begin
            salt = 16'($urandom);
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                len[i] = $urandom_range(1, 6);
                bidx[i] = 0;
            end
            order.delete();
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (mask[idx]) order.push_back(idx);
            end
            req = mask;
            drive_data();
            foreach (order[j]) begin
                wait_grant(1);
                serve(order[j], 1);
                req[order[j]] = 1'b0;
                drive_data();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
